hex_panel_ctrl: RTL and testbench
=================================

HEX_PANEL_CTRL -- requirements
Module: hex_panel_ctrl

Interface
REQ-001 The block SHALL have parameter DEBOUNCE_CYCLES, default 500000, meaning consecutive stable samples needed to accept a key level (10 ms at 50 MHz).
REQ-002 The block SHALL have port clk_clk, input, 1, the single system clock.
REQ-003 The block SHALL have port reset_reset_n, input, 1, asynchronous active-low reset.
REQ-004 The block SHALL have port period_i, input, 28, blink period in clk_clk cycles from the period register.
REQ-005 The block SHALL have port segs_i, input, 28, active-low segment data, digit d on bits [7d+6:7d].
REQ-006 The block SHALL have port push_n_i, input, 4, raw active-low pushbuttons, asynchronous to clk_clk.
REQ-007 The block SHALL have port hex_o, output, 28, registered active-low segment drive to HEX3..HEX0.
REQ-008 The block SHALL have port mode_o, output, 2, current mode: 00 NORMAL, 01 BLINK, 10 FREEZE.
REQ-009 The block SHALL have port cursor_o, output, 2, currently selected digit.
REQ-010 The block SHALL have port tick_o, output, 1, one-cycle pulse at each period wrap.

Function
REQ-011 Each push_n_i bit SHALL pass a 2-flop synchronizer, then a debouncer that updates its stable level only after DEBOUNCE_CYCLES consecutive equal synchronized samples.
REQ-012 A press event SHALL be a one-cycle pulse on a stable 1->0 transition; releases generate no event.
REQ-013 The period counter SHALL count 0..period_i-1, assert tick_o in the cycle count == period_i-1, and wrap to 0 in the next cycle.
REQ-014 If period_i == 0, the counter SHALL hold at 0 and tick_o SHALL stay low.
REQ-015 If period_i drops so that count >= period_i-1, tick_o SHALL assert in the next cycle and the count SHALL wrap.
REQ-016 Blink phase SHALL toggle on every tick_o, but only while mode is BLINK, and SHALL clear on leaving BLINK.
REQ-017 Each KEY0 event SHALL advance mode NORMAL->BLINK->FREEZE->NORMAL; code 11 is unreachable and SHALL decode as NORMAL.
REQ-018 Each KEY1 event SHALL increment cursor modulo 4 (3 wraps to 0).
REQ-019 Each KEY2 event SHALL toggle blank_mask[cursor].
REQ-020 A KEY3 event SHALL clear blank_mask, set cursor to 0 and set mode to NORMAL.
REQ-021 Simultaneous events: KEY3 SHALL override all others; otherwise KEY0, KEY1 and KEY2 SHALL all apply in the same cycle, with KEY2 using the pre-increment cursor.
REQ-022 On entry to FREEZE, segs_i SHALL be captured into a snapshot register; FREEZE SHALL display the snapshot, other modes the live segs_i.
REQ-023 Digit d of hex_o SHALL be 7'h7F when blank_mask[d] is set, or when mode is BLINK, d == cursor and phase is 1; otherwise it SHALL be the selected source digit.
REQ-024 hex_o SHALL have exactly 1 cycle latency from segs_i, blank_mask, cursor, mode and phase.

Reset
REQ-025 Assertion of reset_reset_n low SHALL asynchronously force hex_o = 28'hFFFFFFF, mode_o = 00, cursor_o = 0, tick_o = 0, blank_mask = 0, phase = 0, counters = 0, snapshot = all ones and debounced levels = 1 (released).
REQ-026 A key held low through reset release SHALL produce no press event until it is released and pressed again.

Structure
REQ-027 A package hex_panel_pkg SHALL hold the mode enum, SEG_OFF = 7'h7F, NUM_DIGITS = 4 and the digit-slice width of 7.
REQ-028 A sub-module key_debounce (synchronizer, debounce counter, press pulse) SHALL be instantiated 4 times.

Verification (DEBOUNCE_CYCLES = 4)
REQ-029 Reset with segs_i = 28'h0000000 -> hex_o = 28'hFFFFFFF during reset and 28'h0000000 one cycle after release; mode_o = 00.
REQ-030 period_i = 5 -> tick_o high for 1 cycle every 5; then period_i = 0 -> tick_o never asserts.
REQ-031 KEY0 glitch low for 3 cycles -> no mode change; KEY0 low for 10 cycles -> mode_o = 01 exactly once.
REQ-032 In BLINK with cursor = 2 and period_i = 4 -> hex_o[20:14] alternates between segs_i[20:14] and 7'h7F every 4 cycles; other digits unaffected.
REQ-033 Enter FREEZE with segs_i = 28'h1234567, then change segs_i to 28'h7654321 -> hex_o stays 28'h1234567; KEY2 at cursor 0 -> hex_o[6:0] = 7'h7F.
REQ-034 KEY1 and KEY2 pressed in the same cycle at cursor 3 -> blank_mask[3] toggles and cursor_o = 0; adding KEY3 in that cycle -> mask 0, cursor 0, mode 00.

Source files
------------

// File: rtl/hex_panel_pkg.sv
// hex_panel_pkg: shared types and constants for the hex panel controller.
//   mode_e     - display mode (NORMAL, BLINK, FREEZE)
//   SEG_OFF    - active-low pattern with every segment dark
//   NUM_DIGITS - number of seven-segment digits
//   DIGIT_W    - width of one digit slice
//   next_mode  - mode sequence advanced by KEY0
package hex_panel_pkg;

    typedef enum logic [1:0] {
        MODE_NORMAL = 2'b00,
        MODE_BLINK  = 2'b01,
        MODE_FREEZE = 2'b10
    } mode_e;

    localparam logic [6:0] SEG_OFF    = 7'h7F;
    localparam int         NUM_DIGITS = 4;
    localparam int         DIGIT_W    = 7;

    // The unused code 2'b11 falls into the default arm and returns to NORMAL.
    function automatic mode_e next_mode(input mode_e m);
        return (m == MODE_NORMAL) ? MODE_BLINK :
               (m == MODE_BLINK)  ? MODE_FREEZE : MODE_NORMAL;
    endfunction

endpackage

// File: rtl/key_debounce.sv
// key_debounce: synchronizes, debounces and edge-detects one active-low key.
//   i_clk   - system clock
//   i_rst_n - asynchronous active-low reset
//   i_key_n - raw active-low key, asynchronous to i_clk
//   o_press - one-cycle pulse on an accepted released->pressed transition
module key_debounce #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_key_n,
    output logic o_press
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic [1:0]    r_sync;
    logic [CW-1:0] r_cnt;
    logic          r_level;
    logic          r_armed;
    logic          r_press;
    logic          w_goal;

    // Until a released level has been accepted after reset the only level
    // worth tracking is "released", so a key held through reset cannot
    // produce a press until it is let go and pressed again.
    assign w_goal  = r_armed ? ~r_level : 1'b1;
    assign o_press = r_press;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync  <= 2'b11;
            r_cnt   <= '0;
            r_level <= 1'b1;
            r_armed <= 1'b0;
            r_press <= 1'b0;
        end else begin
            r_sync  <= {r_sync[0], i_key_n};
            r_press <= 1'b0;
            if (r_sync[1] != w_goal) begin
                r_cnt <= '0;
            end else if (r_cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
                r_cnt   <= '0;
                r_armed <= 1'b1;
                r_level <= w_goal;
                r_press <= r_armed & ~w_goal;
            end else begin
                r_cnt <= r_cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/hex_panel_ctrl.sv
// hex_panel_ctrl: four-digit seven-segment panel with blink, freeze, digit
// blanking and a cursor, controlled by four debounced pushbuttons.
//   clk_clk       - system clock
//   reset_reset_n - asynchronous active-low reset
//   period_i      - blink period in clock cycles (0 stops the counter)
//   segs_i        - live active-low segment data, digit d on [7d+6:7d]
//   push_n_i      - raw active-low keys: 0 mode, 1 cursor, 2 blank, 3 clear
//   hex_o         - registered active-low segment drive
//   mode_o        - current mode
//   cursor_o      - selected digit
//   tick_o        - one-cycle pulse at each period wrap
module hex_panel_ctrl
    import hex_panel_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic        clk_clk,
    input  logic        reset_reset_n,
    input  logic [27:0] period_i,
    input  logic [27:0] segs_i,
    input  logic [3:0]  push_n_i,
    output logic [27:0] hex_o,
    output logic [1:0]  mode_o,
    output logic [1:0]  cursor_o,
    output logic        tick_o
);

    logic [3:0]  w_press;
    logic [27:0] w_cnt_nxt;
    logic        w_tick_nxt;
    logic [27:0] w_src;
    logic [27:0] w_hex;
    logic [27:0] r_count;
    logic        r_tick;
    logic        r_phase;
    mode_e       r_mode;
    logic [1:0]  r_cursor;
    logic [3:0]  r_mask;
    logic [27:0] r_snap;
    logic [27:0] r_hex;

    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_key
        key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key (
            .i_clk   (clk_clk),
            .i_rst_n (reset_reset_n),
            .i_key_n (push_n_i[g]),
            .o_press (w_press[g])
        );
    end

    // Tick is registered from the next count, so it is high while the count
    // sits at period-1. If the period shrinks below the running count, the
    // next count already exceeds period-1: tick fires and the count wraps.
    always_comb begin
        w_cnt_nxt  = (period_i <= 28'd1 || r_tick) ? 28'd0 : r_count + 28'd1;
        w_tick_nxt = (period_i != 28'd0) && (w_cnt_nxt >= period_i - 28'd1);
    end

    always_comb begin
        w_hex = '1;
        w_src = (r_mode == MODE_FREEZE) ? r_snap : segs_i;
        for (int d = 0; d < NUM_DIGITS; d++)
            w_hex[d*DIGIT_W +: DIGIT_W] =
                (r_mask[d] || (r_mode == MODE_BLINK && r_phase && r_cursor == 2'(d)))
                    ? SEG_OFF : w_src[d*DIGIT_W +: DIGIT_W];
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            r_count  <= '0;
            r_tick   <= 1'b0;
            r_phase  <= 1'b0;
            r_mode   <= MODE_NORMAL;
            r_cursor <= '0;
            r_mask   <= '0;
            r_snap   <= '1;
            r_hex    <= '1;
        end else begin
            r_count <= w_cnt_nxt;
            r_tick  <= w_tick_nxt;
            r_phase <= (r_mode == MODE_BLINK) && (r_phase ^ r_tick);
            r_hex   <= w_hex;
            if (w_press[3]) begin
                r_mode   <= MODE_NORMAL;
                r_cursor <= '0;
                r_mask   <= '0;
            end else begin
                if (w_press[0]) begin
                    r_mode <= next_mode(r_mode);
                    if (next_mode(r_mode) == MODE_FREEZE)
                        r_snap <= segs_i;
                end
                if (w_press[1])
                    r_cursor <= r_cursor + 2'd1;
                // Blank toggle uses the cursor before any same-cycle increment.
                if (w_press[2])
                    r_mask[r_cursor] <= ~r_mask[r_cursor];
            end
        end
    end

    assign hex_o    = r_hex;
    assign mode_o   = r_mode;
    assign cursor_o = r_cursor;
    assign tick_o   = r_tick;

endmodule

// File: tb/tb_hex_panel_ctrl.sv
// tb_hex_panel_ctrl: directed self-checking bench for hex_panel_ctrl.
module tb_hex_panel_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [27:0] period;
    logic [27:0] segs;
    logic [3:0]  push_n;
    logic [27:0] hex;
    logic [1:0]  mode;
    logic [1:0]  cursor;
    logic        tick;

    int n_checks = 0;
    int n_errors = 0;

    hex_panel_ctrl #(.DEBOUNCE_CYCLES(4)) dut (
        .clk_clk       (clk),
        .reset_reset_n (rst_n),
        .period_i      (period),
        .segs_i        (segs),
        .push_n_i      (push_n),
        .hex_o         (hex),
        .mode_o        (mode),
        .cursor_o      (cursor),
        .tick_o        (tick)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press(input logic [3:0] keys, input int len);
        push_n = ~keys;
        cycles(len);
        push_n = 4'hF;
        cycles(12);
    endtask

    initial begin
        int          ticks;
        int          first;
        int          bad;
        int          f;
        logic        d [24];
        logic [27:0] exp_hex;

        rst_n  = 1'b0;
        period = 28'd0;
        segs   = 28'h0000000;
        push_n = 4'hF;
        cycles(3);
        check("reset_hex", 32'(hex), 32'h0FFFFFFF);
        check("reset_mode", 32'(mode), 32'd0);
        check("reset_cursor", 32'(cursor), 32'd0);
        check("reset_tick", 32'(tick), 32'd0);
        rst_n = 1'b1;
        cycles(1);
        check("hex_after_release", 32'(hex), 32'h0000000);
        cycles(10);

        // period 5: one tick every 5 cycles
        period = 28'd5;
        ticks = 0; first = -1; bad = 0;
        for (int i = 0; i < 20; i++) begin
            cycles(1);
            if (tick) begin
                ticks++;
                if (first < 0) first = i;
                else if ((i - first) % 5 != 0) bad++;
            end
        end
        check("tick_count_p5", 32'(ticks), 32'd4);
        check("tick_spacing_p5", 32'(bad), 32'd0);
        period = 28'd0;
        cycles(2);
        ticks = 0;
        for (int i = 0; i < 20; i++) begin
            cycles(1);
            if (tick) ticks++;
        end
        check("tick_count_p0", 32'(ticks), 32'd0);

        // period shrinks below running count: tick next cycle, then wrap
        period = 28'd100;
        cycles(12);
        period = 28'd5;
        cycles(1);
        check("tick_on_shrink", 32'(tick), 32'd1);
        cycles(1);
        check("tick_after_shrink", 32'(tick), 32'd0);

        // debounce: short glitch rejected, long press accepted once
        press(4'b0001, 3);
        check("glitch_mode", 32'(mode), 32'd0);
        press(4'b0001, 10);
        check("press_mode_blink", 32'(mode), 32'd1);

        // blink on cursor 2 with period 4
        segs = 28'h5A5A5A5;
        press(4'b0010, 10);
        press(4'b0010, 10);
        check("cursor_two", 32'(cursor), 32'd2);
        period = 28'd4;
        cycles(4);
        bad = 0;
        for (int i = 0; i < 24; i++) begin
            cycles(1);
            d[i] = (hex[20:14] == 7'h7F);
            if (!d[i] && hex[20:14] != segs[20:14]) bad++;
            if (hex[13:0] != segs[13:0] || hex[27:21] != segs[27:21]) bad++;
        end
        check("blink_other_digits", 32'(bad), 32'd0);
        f = 0;
        for (int i = 4; i >= 1; i--)
            if (d[i] != d[i-1]) f = i;
        check("blink_edge_found", 32'(f != 0), 32'd1);
        bad = 0;
        if (f != 0)
            for (int i = f; i < f + 16; i++)
                if (d[i] != (d[f] ^ (((i - f) / 4) % 2 == 1))) bad++;
        check("blink_alternation", 32'(bad), 32'd0);

        // freeze holds the snapshot; blanking still applies
        segs = 28'h1234567;
        cycles(2);
        press(4'b0001, 10);
        check("mode_freeze", 32'(mode), 32'd2);
        segs = 28'h7654321;
        cycles(3);
        check("freeze_hex", 32'(hex), 32'h1234567);
        press(4'b0010, 10);
        press(4'b0010, 10);
        check("cursor_wrap_zero", 32'(cursor), 32'd0);
        press(4'b0100, 10);
        check("freeze_blank_d0", 32'(hex), 32'h123457F);

        // back to NORMAL, cursor 3, then KEY1+KEY2 together
        press(4'b0001, 10);
        check("mode_normal", 32'(mode), 32'd0);
        press(4'b0010, 10);
        press(4'b0010, 10);
        press(4'b0010, 10);
        check("cursor_three", 32'(cursor), 32'd3);
        press(4'b0110, 10);
        exp_hex = segs;
        exp_hex[6:0]   = 7'h7F;
        exp_hex[27:21] = 7'h7F;
        check("combo_blank_d3", 32'(hex), 32'(exp_hex));
        check("combo_cursor", 32'(cursor), 32'd0);

        // KEY3 overrides everything in the same cycle
        press(4'b0010, 10);
        press(4'b0001, 10);
        check("pre_clear_mode", 32'(mode), 32'd1);
        check("pre_clear_cursor", 32'(cursor), 32'd1);
        press(4'b1111, 10);
        check("clear_mode", 32'(mode), 32'd0);
        check("clear_cursor", 32'(cursor), 32'd0);
        check("clear_hex", 32'(hex), 32'(segs));

        // key held through reset gives no press until released and re-pressed
        push_n = 4'b1110;
        rst_n  = 1'b0;
        cycles(3);
        check("reset2_hex", 32'(hex), 32'h0FFFFFFF);
        rst_n = 1'b1;
        cycles(15);
        check("held_no_press", 32'(mode), 32'd0);
        push_n = 4'hF;
        cycles(12);
        check("release_no_press", 32'(mode), 32'd0);
        press(4'b0001, 10);
        check("repress_mode", 32'(mode), 32'd1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
